// File: rtl/filter_pad.sv
// filter_pad: wraps a width x height RGB raster in a one-pixel zero border,
// producing a (width+2) x (height+2) stream for the downstream sharpen filter.
// Incoming pixels are buffered in a row FIFO and released row by row.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   newFrame            - one-cycle frame-start pulse (aborts any frame in flight)
//   iValid, iR/iG/iB    - demosaiced input pixel in raster order
//   oValid, oR/oG/oB    - padded output pixel (zero during gaps)
//   oDone               - one-cycle pulse after the last padded pixel
//   oOverflow           - sticky flag: an input pixel was dropped on a full FIFO
module filter_pad #(
    parameter int unsigned width  = 320,
    parameter int unsigned height = 240,
    parameter int unsigned depth  = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       newFrame,
    input  logic       iValid,
    input  logic [7:0] iR,
    input  logic [7:0] iG,
    input  logic [7:0] iB,
    output logic       oValid,
    output logic [7:0] oR,
    output logic [7:0] oG,
    output logic [7:0] oB,
    output logic       oDone,
    output logic       oOverflow
);

    localparam int unsigned AW   = $clog2(depth);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = $clog2(width + 2);
    localparam int unsigned RW   = $clog2(height + 1);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [2:0] {
        S_IDLE, S_TOP, S_LEFT, S_BODY, S_RIGHT, S_BOTTOM, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d, waddr;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d, done_q, done_d;
    pixel_t            pix_q, pix_d, rd_data;
    pixel_t            mem_q [depth];
    logic              push, pop, accept, full, empty;

    assign full    = (cnt_q == CNTW'(depth));
    assign empty   = (cnt_q == '0);
    assign accept  = iValid && (state_q != S_IDLE) && (state_q != S_DONE);
    assign rd_data = mem_q[rd_q];

    // Next-state, FIFO bookkeeping and output selection
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        pix_d   = '0;
        push    = 1'b0;
        pop     = 1'b0;
        waddr   = wr_q;

        if (newFrame) begin
            // Flush, then the coincident pixel becomes entry 0 of the new frame
            state_d = S_TOP;
            col_d   = '0;
            row_d   = '0;
            ovf_d   = 1'b0;
            rd_d    = '0;
            waddr   = '0;
            push    = iValid;
            wr_d    = iValid ? AW'(1) : '0;
            cnt_d   = iValid ? CNTW'(1) : '0;
        end else begin
            unique case (state_q)
                S_TOP, S_BOTTOM: begin
                    valid_d = 1'b1;
                    if (col_q == CW'(width + 1)) begin
                        col_d   = '0;
                        state_d = (state_q == S_TOP) ? S_LEFT : S_DONE;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
                S_LEFT: begin
                    if (!empty) begin
                        valid_d = 1'b1;
                        col_d   = '0;
                        state_d = S_BODY;
                    end
                end
                S_BODY: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        valid_d = 1'b1;
                        pix_d   = rd_data;
                        if (col_q == CW'(width - 1)) begin
                            col_d   = '0;
                            state_d = S_RIGHT;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
                S_RIGHT: begin
                    valid_d = 1'b1;
                    if (row_q == RW'(height - 1)) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_BOTTOM;
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = S_LEFT;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase

            // A pop in the same cycle frees the slot, so full+push+pop succeeds
            push = accept && (!full || pop);
            if (accept && full && !pop) ovf_d = 1'b1;
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNTW'(1);
                2'b01:   cnt_d = cnt_q - CNTW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers are reset
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[waddr] <= pixel_t'({iR, iG, iB});
    end

    assign oValid    = valid_q;
    assign oR        = pix_q.r;
    assign oG        = pix_q.g;
    assign oB        = pix_q.b;
    assign oDone     = done_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_filter_pad.sv
// Scoreboard bench for filter_pad: instance 0 (4x3, depth 8) covers framing,
// abort and reset; instance 1 (4x3, depth 4) covers FIFO overflow.
module tb_filter_pad;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        nf  [2];
    logic        iv  [2];
    logic [23:0] pix [2];
    logic        ov  [2];
    logic        od  [2];
    logic        oof [2];
    logic [7:0]  orr [2];
    logic [7:0]  og  [2];
    logic [7:0]  ob  [2];

    logic [23:0] exp0[$];
    logic [23:0] exp1[$];
    int          errs = 0;
    int          checks = 0;
    int          done_cnt [2];
    logic        prev_ov  [2];
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    filter_pad #(.width(4), .height(3), .depth(8)) dut0 (
        .clk(clk), .reset(rst[0]), .newFrame(nf[0]), .iValid(iv[0]),
        .iR(pix[0][23:16]), .iG(pix[0][15:8]), .iB(pix[0][7:0]),
        .oValid(ov[0]), .oR(orr[0]), .oG(og[0]), .oB(ob[0]),
        .oDone(od[0]), .oOverflow(oof[0]));

    filter_pad #(.width(4), .height(3), .depth(4)) dut1 (
        .clk(clk), .reset(rst[1]), .newFrame(nf[1]), .iValid(iv[1]),
        .iR(pix[1][23:16]), .iG(pix[1][15:8]), .iB(pix[1][7:0]),
        .oValid(ov[1]), .oR(orr[1]), .oG(og[1]), .oB(ob[1]),
        .oDone(od[1]), .oOverflow(oof[1]));

    function automatic logic [23:0] px(input int v);
        return {8'(v), 8'(v * 3), 8'(255 - v)};
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic exp_push(input int k, input logic [23:0] v);
        if (k == 0) exp0.push_back(v);
        else        exp1.push_back(v);
    endtask

    task automatic exp_zeros(input int k, input int n);
        repeat (n) exp_push(k, 24'h0);
    endtask

    task automatic exp_row(input int k, input int a, input int b, input int c, input int d);
        exp_push(k, 24'h0);
        exp_push(k, px(a)); exp_push(k, px(b)); exp_push(k, px(c)); exp_push(k, px(d));
        exp_push(k, 24'h0);
    endtask

    task automatic exp_std(input int k);
        exp_zeros(k, 6);
        exp_row(k, 1, 2, 3, 4);
        exp_row(k, 5, 6, 7, 8);
        exp_row(k, 9, 10, 11, 12);
        exp_zeros(k, 6);
    endtask

    // Output monitor: pops the scoreboard on every valid beat
    task automatic mon(input int k);
        logic [23:0] got;
        logic [23:0] want;
        got = {orr[k], og[k], ob[k]};
        checks++;
        if (ov[k] === 1'b1) begin
            if (qsize(k) == 0) begin
                errs++;
                $display("FAIL dut%0d unexpected_beat got=%h required=no beat", k, got);
            end else begin
                want = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                if (got !== want) begin
                    errs++;
                    $display("FAIL dut%0d beat got=%h required=%h", k, got, want);
                end
            end
        end else if (ov[k] !== 1'b0 || got !== 24'h0) begin
            errs++;
            $display("FAIL dut%0d gap oValid=%b pixel=%h required 0/000000", k, ov[k], got);
        end
        if (od[k] !== 1'b0) begin
            done_cnt[k]++;
            checks++;
            if (prev_ov[k] !== 1'b1 || qsize(k) != 0 || ov[k] !== 1'b0) begin
                errs++;
                $display("FAIL dut%0d done_position prev_valid=%b pending=%0d required 1/0",
                         k, prev_ov[k], qsize(k));
            end
        end
        prev_ov[k] = ov[k];
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0);
            mon(1);
        end
    end

    task automatic drive(input int k, input bit nfv, input bit v, input logic [23:0] p,
                         input bit r);
        nf[k] = nfv; iv[k] = v; pix[k] = p; rst[k] = r;
        @(posedge clk); #1;
        nf[k] = 1'b0; iv[k] = 1'b0; pix[k] = '0; rst[k] = 1'b0;
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) drive(k, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic pixels(input int k, input int start, input int n);
        for (int i = 0; i < n; i++) drive(k, 1'b0, 1'b1, px(start + i), 1'b0);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic wait_done(input int k, input int budget);
        int start;
        bit seen;
        start = done_cnt[k];
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (done_cnt[k] != start) seen = 1'b1;
        end
        #1;
        check($sformatf("dut%0d done_seen", k), int'(seen), 1);
        check($sformatf("dut%0d queue_drained", k), qsize(k), 0);
    endtask

    initial begin
        int d0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; nf[k] = 1'b0; iv[k] = 1'b0; pix[k] = '0;
            done_cnt[k] = 0; prev_ov[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d reset_valid", k), int'(ov[k]), 0);
            check($sformatf("dut%0d reset_pixel", k), int'({orr[k], og[k], ob[k]}), 0);
            check($sformatf("dut%0d reset_done", k), int'(od[k]), 0);
            check($sformatf("dut%0d reset_ovf", k), int'(oof[k]), 0);
        end
        @(posedge clk); #1;

        // Rows separated by 16 idle cycles
        exp_std(0);
        drive(0, 1'b1, 1'b0, '0, 1'b0);
        pixels(0, 1, 4); idle(0, 16);
        pixels(0, 5, 4); idle(0, 16);
        pixels(0, 9, 4);
        wait_done(0, 300);
        check("gap16 overflow", int'(oof[0]), 0);
        idle(0, 4);

        // All 12 pixels back to back
        exp_std(0);
        drive(0, 1'b1, 1'b0, '0, 1'b0);
        pixels(0, 1, 12);
        wait_done(0, 300);
        check("b2b overflow", int'(oof[0]), 0);
        idle(0, 4);

        // First pixel arrives on the newFrame cycle
        exp_std(0);
        drive(0, 1'b1, 1'b1, px(1), 1'b0);
        pixels(0, 2, 3); idle(0, 2);
        pixels(0, 5, 4); idle(0, 2);
        pixels(0, 9, 4);
        wait_done(0, 300);
        check("nfpix overflow", int'(oof[0]), 0);
        idle(0, 4);

        // Abort after 5 pixels: 4 top zeros escape, then a clean frame
        d0 = done_cnt[0];
        exp_zeros(0, 4);
        exp_std(0);
        drive(0, 1'b1, 1'b1, px(50), 1'b0);
        pixels(0, 51, 4);
        drive(0, 1'b1, 1'b0, '0, 1'b0);
        pixels(0, 1, 12);
        wait_done(0, 300);
        idle(0, 5);
        check("abort done_count", done_cnt[0] - d0, 1);
        check("abort overflow", int'(oof[0]), 0);

        // Reset while in BODY after two pixels have been emitted
        exp_zeros(0, 7);
        exp_push(0, px(1));
        exp_push(0, px(2));
        drive(0, 1'b1, 1'b0, '0, 1'b0);
        pixels(0, 1, 4);
        idle(0, 5);
        drive(0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("midreset valid", int'(ov[0]), 0);
        check("midreset done", int'(od[0]), 0);
        @(posedge clk); #1;
        pixels(0, 20, 8);
        idle(0, 30);
        check("midreset queue_drained", qsize(0), 0);
        check("midreset overflow", int'(oof[0]), 0);

        // Overflow on depth-4 instance: fifth pixel dropped while held in TOP
        exp_zeros(1, 6);
        exp_row(1, 1, 2, 3, 4);
        exp_row(1, 6, 7, 8, 9);
        exp_row(1, 10, 11, 12, 13);
        exp_zeros(1, 6);
        drive(1, 1'b1, 1'b0, '0, 1'b0);
        pixels(1, 1, 5);
        check("ovf flag_set", int'(oof[1]), 1);
        idle(1, 20);
        pixels(1, 6, 4); idle(1, 4);
        pixels(1, 10, 4);
        wait_done(1, 300);
        check("ovf flag_sticky", int'(oof[1]), 1);

        idle(0, 3);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
